// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button edge detect, count-tick prescaler, clear/lap strobes, overflow.
// Optional lap support is compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int DIV_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       lap,
  input  logic       chain_cout,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       disp_hold,
  output logic       running,
  output logic       ovf,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_OVF   = 3'd4
  } st_e;

  localparam logic [DIV_W-1:0] PRE_MAX = DIV_W'(TICK_DIV - 1);

  st_e              state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic             sr_q, sr_qq, stp_q, stp_qq;
  logic             sr_pr, stp_pr, lap_pr;
  logic             counting, tick_due;
  logic             cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d;
  logic             lap_load_q, lap_load_d, disp_hold_q, disp_hold_d;
  logic             running_q, running_d, ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      {sr_q, sr_qq, stp_q, stp_qq} <= '0;
    end else begin
      sr_q   <= start_resume;
      sr_qq  <= sr_q;
      stp_q  <= stop;
      stp_qq <= stp_q;
    end
  end

  assign sr_pr  = sr_q & ~sr_qq;
  assign stp_pr = stp_q & ~stp_qq;

`ifdef STOPWATCH_LAP_EN
  logic lap_q, lap_qq;
  always_ff @(posedge clk) begin
    if (reset) begin
      {lap_q, lap_qq} <= '0;
    end else begin
      lap_q  <= lap;
      lap_qq <= lap_q;
    end
  end
  assign lap_pr = lap_q & ~lap_qq;
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign lap_pr     = 1'b0;
`endif

  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick_due = counting && (pre_q == PRE_MAX);

  // State register; every output is registered alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b0;
      lap_load_q  <= 1'b0;
      disp_hold_q <= 1'b0;
      running_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_q   <= cnt_clr_d;
      lap_load_q  <= lap_load_d;
      disp_hold_q <= disp_hold_d;
      running_q   <= running_d;
      ovf_q       <= ovf_d;
    end
  end

  // Stop outranks a due overflow so a pause never loses the frozen value
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sr_pr) state_d = S_RUN;
      S_RUN, S_LAP: begin
        if (stp_pr)                      state_d = S_PAUSE;
        else if (tick_due && chain_cout) state_d = S_OVF;
        else if (lap_pr)                 state_d = S_LAP;
        else if (sr_pr)                  state_d = S_RUN;
      end
      S_PAUSE: begin
        if (stp_pr)     state_d = S_IDLE;
        else if (sr_pr) state_d = S_RUN;
      end
      S_OVF:   if (stp_pr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // PAUSE holds the prescaler so the partial tick period carries over
  always_comb begin
    pre_d = '0;
    if (counting)                pre_d = tick_due ? '0 : pre_q + DIV_W'(1);
    else if (state_q == S_PAUSE) pre_d = pre_q;
  end

  always_comb begin
    cnt_en_d    = tick_due && !chain_cout &&
                  ((state_d == S_RUN) || (state_d == S_LAP));
    cnt_clr_d   = stp_pr && ((state_q == S_PAUSE) || (state_q == S_OVF));
    lap_load_d  = lap_pr && (state_d == S_LAP);
    disp_hold_d = (state_d == S_LAP);
    running_d   = (state_d == S_RUN) || (state_d == S_LAP);
    ovf_d       = (state_d == S_OVF);
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign lap_load  = lap_load_q;
  assign disp_hold = disp_hold_q;
  assign running   = running_q;
  assign ovf       = ovf_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl (TICK_DIV=10); lap checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;
  logic       clk = 1'b0;
  logic       reset, start_resume, stop, lap, chain_cout;
  logic       cnt_en, cnt_clr, lap_load, disp_hold, running, ovf;
  logic [2:0] state;

  stopwatch_ctrl #(.TICK_DIV(10), .DIV_W(4)) dut (
    .clk(clk), .reset(reset), .start_resume(start_resume), .stop(stop), .lap(lap),
    .chain_cout(chain_cout), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .lap_load(lap_load),
    .disp_hold(disp_hold), .running(running), .ovf(ovf), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (state,ovf,run,hold,lapld,clr,en)", tag, got, exp);
    end
  endtask

  // Expected output vector; running/ovf/hold follow directly from the state
  function automatic logic [8:0] V(input logic [2:0] st, input logic en, input logic clr,
                                   input logic ll);
    return {st, st == 3'd4, (st == 3'd1) || (st == 3'd3), st == 3'd3, ll, clr, en};
  endfunction

  task automatic expv(input int at, input string tag, input logic [8:0] v);
    sb.push_back('{at, $sformatf("%s@%0d", tag, at), v});
  endtask

  // Counting window: ticks land every 10 cycles after cycle ref
  task automatic win(input int a, input int b, input int ref_c, input string tag,
                     input logic [2:0] st);
    for (int c = a; c <= b; c++)
      expv(c, tag, V(st, (c > ref_c) && ((c - ref_c) % 10 == 0), 1'b0, 1'b0));
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [8:0] got;
    got = {state, ovf, running, disp_hold, lap_load, cnt_clr, cnt_en};
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, got, sb[i].v);
        sb.delete(i);
      end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: stuck at cycle %0d, want completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, p, x, t1, y0, t3, x2, t2, y, z;
    reset = 1'b1; start_resume = 1'b0; stop = 1'b0; lap = 1'b0; chain_cout = 1'b0;

    // reset, then start held high
    wait_to(1);
    for (int c = 2; c <= 5; c++) expv(c, "rst", V(3'd0, 1'b0, 1'b0, 1'b0));
    wait_to(5);
    reset = 1'b0; start_resume = 1'b1;
    t0 = 7;
    expv(6, "idle0", V(3'd0, 1'b0, 1'b0, 1'b0));
    win(t0, t0 + 36, t0, "run1", 3'd1);
    for (int c = t0 + 37; c <= t0 + 57; c++) expv(c, "pause1", V(3'd2, 1'b0, 1'b0, 1'b0));
    wait_to(t0 + 5);  start_resume = 1'b0;
    wait_to(t0 + 35); stop = 1'b1;
    wait_to(t0 + 36); stop = 1'b0;

    // resume with held prescaler, then stop twice
    p = t0 + 57;
    wait_to(p); start_resume = 1'b1;
    expv(p + 1, "pause1", V(3'd2, 1'b0, 1'b0, 1'b0));
    win(p + 2, p + 9, p - 5, "resume", 3'd1);
    for (int c = p + 10; c <= p + 12; c++) expv(c, "pause2", V(3'd2, 1'b0, 1'b0, 1'b0));
    expv(p + 13, "clr", V(3'd0, 1'b0, 1'b1, 1'b0));
    expv(p + 14, "idle1", V(3'd0, 1'b0, 1'b0, 1'b0));
    wait_to(p + 1);  start_resume = 1'b0;
    wait_to(p + 8);  stop = 1'b1;
    wait_to(p + 9);  stop = 1'b0;
    wait_to(p + 11); stop = 1'b1;
    wait_to(p + 12); stop = 1'b0;

    // overflow on a due tick
    x = p + 16;
    wait_to(x); start_resume = 1'b1;
    t1 = x + 2;
    expv(x + 1, "idle2", V(3'd0, 1'b0, 1'b0, 1'b0));
    win(t1, t1 + 9, t1, "run_ov", 3'd1);
    for (int c = t1 + 10; c <= t1 + 17; c++) expv(c, "ovf", V(3'd4, 1'b0, 1'b0, 1'b0));
    expv(t1 + 18, "ovf_clr", V(3'd0, 1'b0, 1'b1, 1'b0));
    expv(t1 + 19, "idle3", V(3'd0, 1'b0, 1'b0, 1'b0));
    wait_to(x + 1);   start_resume = 1'b0;
    wait_to(t1 + 5);  chain_cout = 1'b1;
    wait_to(t1 + 12); start_resume = 1'b1;
    wait_to(t1 + 13); start_resume = 1'b0;
    wait_to(t1 + 16); stop = 1'b1; chain_cout = 1'b0;
    wait_to(t1 + 17); stop = 1'b0;

    // stop beats overflow in the same cycle
    y0 = t1 + 20;
    wait_to(y0); start_resume = 1'b1;
    t3 = y0 + 2;
    expv(y0 + 1, "idle4", V(3'd0, 1'b0, 1'b0, 1'b0));
    win(t3, t3 + 9, t3, "run_sv", 3'd1);
    for (int c = t3 + 10; c <= t3 + 13; c++) expv(c, "stop_ovf", V(3'd2, 1'b0, 1'b0, 1'b0));
    expv(t3 + 14, "clr2", V(3'd0, 1'b0, 1'b1, 1'b0));
    expv(t3 + 15, "idle5", V(3'd0, 1'b0, 1'b0, 1'b0));
    wait_to(y0 + 1);  start_resume = 1'b0;
    wait_to(t3 + 3);  chain_cout = 1'b1;
    wait_to(t3 + 8);  stop = 1'b1;
    wait_to(t3 + 9);  stop = 1'b0;
    wait_to(t3 + 11); chain_cout = 1'b0;
    wait_to(t3 + 12); stop = 1'b1;
    wait_to(t3 + 13); stop = 1'b0;

    // lap sequence (or lap ignored without the feature)
    x2 = t3 + 16;
    wait_to(x2); start_resume = 1'b1;
    t2 = x2 + 2;
    expv(x2 + 1, "idle6", V(3'd0, 1'b0, 1'b0, 1'b0));
`ifdef STOPWATCH_LAP_EN
    win(t2, t2 + 4, t2, "run3", 3'd1);
    expv(t2 + 5, "lap1", V(3'd3, 1'b0, 1'b0, 1'b1));
    win(t2 + 6, t2 + 13, t2, "lap_cnt", 3'd3);
    expv(t2 + 14, "lap2", V(3'd3, 1'b0, 1'b0, 1'b1));
    win(t2 + 15, t2 + 17, t2, "lap_hold", 3'd3);
    win(t2 + 18, t2 + 23, t2, "lap_exit", 3'd1);
`else
    win(t2, t2 + 23, t2, "nolap", 3'd1);
`endif
    wait_to(x2 + 1);  start_resume = 1'b0;
    wait_to(t2 + 3);  lap = 1'b1;
    wait_to(t2 + 4);  lap = 1'b0;
    wait_to(t2 + 12); lap = 1'b1;
    wait_to(t2 + 13); lap = 1'b0;
    wait_to(t2 + 16); start_resume = 1'b1;
    wait_to(t2 + 17); start_resume = 1'b0;

    // all three buttons together while running
    y = t2 + 22;
    wait_to(y);
    for (int c = y + 2; c <= y + 5; c++) expv(c, "all3", V(3'd2, 1'b0, 1'b0, 1'b0));
    expv(y + 6, "clr3", V(3'd0, 1'b0, 1'b1, 1'b0));
    expv(y + 7, "idle7", V(3'd0, 1'b0, 1'b0, 1'b0));
    start_resume = 1'b1; stop = 1'b1; lap = 1'b1;
    wait_to(y + 1); start_resume = 1'b0; stop = 1'b0; lap = 1'b0;
    wait_to(y + 4); stop = 1'b1;
    wait_to(y + 5); stop = 1'b0;

    // reset mid-operation, start held through reset release
    z = y + 8;
    wait_to(z); start_resume = 1'b1;
    expv(z + 1, "idle8", V(3'd0, 1'b0, 1'b0, 1'b0));
`ifdef STOPWATCH_LAP_EN
    win(z + 2, z + 5, z + 2, "run5", 3'd1);
    expv(z + 6, "lap3", V(3'd3, 1'b0, 1'b0, 1'b1));
    win(z + 7, z + 8, z + 2, "lap_pre_rst", 3'd3);
`else
    win(z + 2, z + 8, z + 2, "run5", 3'd1);
`endif
    for (int c = z + 9; c <= z + 11; c++) expv(c, "rst_mid", V(3'd0, 1'b0, 1'b0, 1'b0));
    win(z + 12, z + 14, z + 12, "run_after_rst", 3'd1);
    wait_to(z + 1);  start_resume = 1'b0;
    wait_to(z + 4);  lap = 1'b1;
    wait_to(z + 5);  lap = 1'b0;
    wait_to(z + 8);  reset = 1'b1; start_resume = 1'b1;
    wait_to(z + 10); reset = 1'b0;
    wait_to(z + 16); start_resume = 1'b0;

    wait_to(z + 20);
    foreach (sb[i]) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: never compared, want checked by cycle %0d", sb[i].tag, sb[i].at);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the stopwatch counter chain (cascaded mod-N digit counters) from three user buttons.
- Generates the divided count-enable tick, the chain clear, the lap capture and display-hold controls.
- Detects full-scale overflow from the chain's terminal carry.
- Sits between the button inputs and the counter/display datapath of the watch.

Parameters:
TICK_DIV, 10, clk cycles per count tick (>=2)
DIV_W, 4, prescaler width; must satisfy 2**DIV_W >= TICK_DIV

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start_resume  input  1  start/resume button level, synchronous to clk
stop  input  1  stop/clear button level
lap  input  1  lap button level
chain_cout  input  1  combinational terminal-count flag of the counter chain (all stages at max)
cnt_en  output  1  one-cycle count tick to the counter chain
cnt_clr  output  1  one-cycle synchronous clear to the counter chain
lap_load  output  1  one-cycle strobe: capture chain value into the lap register
disp_hold  output  1  display shows lap register while high
running  output  1  high in RUN or LAP
ovf  output  1  high in OVF
state  output  3  IDLE=0, RUN=1, PAUSE=2, LAP=3, OVF=4

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset:
  - state=IDLE; prescaler=0; all edge-detect registers=0.
  - All outputs are 0.
- Because the edge registers reset to 0, a button held high through reset release yields exactly one press.
- Edge detect, per button:
  - b_q <= button; b_qq <= b_q; press = b_q & ~b_qq.
  - A button rising before edge k produces press during cycle k..k+1; the state changes at edge k+1.
- Press priority within one cycle: stop > lap > start_resume. Lower-priority presses in the same cycle are discarded.
- All outputs are registered.
- IDLE:
  - start_resume -> RUN. stop and lap are ignored.
- RUN:
  - stop -> PAUSE.
  - lap -> LAP, with lap_load=1 for 1 cycle.
  - Tick overflow (below) -> OVF.
- LAP (counting continues, disp_hold=1):
  - lap -> LAP, with a new lap_load pulse; the displayed lap updates.
  - start_resume -> RUN, and disp_hold drops.
  - stop -> PAUSE, and disp_hold drops.
- PAUSE:
  - start_resume -> RUN.
  - stop -> IDLE, with cnt_clr=1 for 1 cycle.
  - lap is ignored.
- OVF:
  - stop -> IDLE, with cnt_clr=1 for 1 cycle.
  - All other presses are ignored.
- Prescaler:
  - In RUN/LAP, counts 0..TICK_DIV-1 and wraps to 0.
  - cnt_en=1 for the cycle following the prescaler reaching TICK_DIV-1; this gives exactly one tick per TICK_DIV cycles.
  - In PAUSE it holds its value, so the fractional period resumes.
  - Cleared to 0 in IDLE and OVF.
- Overflow:
  - Applies when a tick is due and chain_cout=1 in that same cycle.
  - cnt_en is suppressed and the next state is OVF, so the chain freezes at max.
  - A stop press in the same cycle wins: go to PAUSE, no tick.
- cnt_en is never asserted outside RUN/LAP.
- cnt_clr and lap_load are never asserted in the same cycle.
- running=1 in RUN/LAP; ovf=1 in OVF; disp_hold=1 only in LAP.
- Reset mid-operation takes priority over everything. Next cycle is the reset state; no cnt_clr is issued, because the counter chain shares `reset`.

Optional Feature:
STOPWATCH_LAP_EN.
- Defined: lap input and LAP state behave as above.
- Undefined:
  - The lap input is unused and LAP is unreachable.
  - lap_load and disp_hold are tied 0.
  - The stop>start_resume priority still applies.

Test Plan (TICK_DIV=10):
1. Reset 5 cycles, then start_resume held high -> state=1 two edges after the first sampled high; cnt_en pulses every 10 cycles; no other output high.
2. RUN for 35 cycles, stop pulse -> PAUSE after 3 ticks. Wait 20 cycles: no cnt_en. Resume -> next tick arrives after the 10-cycle period minus the cycles already elapsed before pause (prescaler held). Stop twice -> IDLE with a single-cycle cnt_clr.
3. In RUN, lap pulse -> one-cycle lap_load, state=3, disp_hold=1, ticks continue. Second lap -> another lap_load, still LAP. start_resume -> RUN, disp_hold=0.
4. In RUN, drive chain_cout=1 before a tick -> no cnt_en, state=4, ovf=1. start_resume ignored; stop -> IDLE, cnt_clr pulse, ovf=0.
5. stop, lap and start_resume pressed in the same cycle while in RUN -> PAUSE, no lap_load. Assert reset while in LAP -> all outputs 0, state=0 next cycle.
6. Build without STOPWATCH_LAP_EN: lap pulses in RUN -> no state change; lap_load and disp_hold stay 0.
